// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU issue scheduler: decoded op, FSM state, M-extension detection.
package alu_sched_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  function automatic logic is_muldiv(input op_t op);
    return ((op.opcode == OPC_OP) || (op.opcode == OPC_OP_32)) &&
           (op.funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Issue scheduler for the shared integer ALU: round-robin grant, latency-timed EXEC,
// and a tagged result held on the CDB until accepted.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_REQ        = 4,
  parameter int TAG_WIDTH      = 6,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  op_t                   req_op  [NUM_REQ],
  input  logic [DATA_WIDTH-1:0] req_lhs [NUM_REQ],
  input  logic [DATA_WIDTH-1:0] req_rhs [NUM_REQ],
  input  logic [TAG_WIDTH-1:0]  req_tag [NUM_REQ],
  output op_t                   alu_op,
  output logic [DATA_WIDTH-1:0] alu_lhs,
  output logic [DATA_WIDTH-1:0] alu_rhs,
  output logic                  alu_lhs_valid,
  output logic                  alu_rhs_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_result_valid,
  output logic                  cdb_valid,
  input  logic                  cdb_ready,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;

  sched_state_t          state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  op_t                   op_q, op_d;
  logic [DATA_WIDTH-1:0] lhs_q, lhs_d;
  logic [DATA_WIDTH-1:0] rhs_q, rhs_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;

  logic                  arb_en;
  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  xfer;
  logic                  capture;
  op_t                   sel_op;
  logic [DATA_WIDTH-1:0] sel_lhs;
  logic [DATA_WIDTH-1:0] sel_rhs;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [PTR_W-1:0]      sel_idx;

  assign arb_req   = req_valid & {NUM_REQ{arb_en}};
  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign capture   = (state_q == EXEC) && (cnt_q == '0) && !flush;
  assign cdb_data  = cdb_data_q;
  assign cdb_tag   = cdb_tag_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_op  = '0;
    sel_lhs = '0;
    sel_rhs = '0;
    sel_tag = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op  = req_op[i];
        sel_lhs = req_lhs[i];
        sel_rhs = req_rhs[i];
        sel_tag = req_tag[i];
        sel_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      tag_q      <= '0;
      cdb_data_q <= '0;
      cdb_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      tag_q      <= tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_tag_q  <= cdb_tag_d;
    end
  end

  // Flush outranks both CDB acceptance and a new grant.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (xfer) state_d = EXEC;
        EXEC:    if (cnt_q == '0) state_d = HOLD;
        HOLD:    if (cdb_ready) state_d = xfer ? EXEC : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state_q != IDLE);
    cdb_valid     = (state_q == HOLD);
    alu_lhs_valid = (state_q == EXEC);
    alu_rhs_valid = (state_q == EXEC);
    alu_op        = (state_q == EXEC) ? op_q  : '0;
    alu_lhs       = (state_q == EXEC) ? lhs_q : '0;
    alu_rhs       = (state_q == EXEC) ? rhs_q : '0;
    arb_en        = rst_n && !flush &&
                    ((state_q == IDLE) || ((state_q == HOLD) && cdb_ready));
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    lhs_d      = lhs_q;
    rhs_d      = rhs_q;
    tag_d      = tag_q;
    cdb_data_d = cdb_data_q;
    cdb_tag_d  = cdb_tag_q;
    if (xfer) begin
      op_d     = sel_op;
      lhs_d    = sel_lhs;
      rhs_d    = sel_rhs;
      tag_d    = sel_tag;
      cnt_d    = is_muldiv(sel_op) ? CNT_W'(MULDIV_LATENCY - 1) : '0;
      rr_ptr_d = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end else if ((state_q == EXEC) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (capture) begin
      cdb_data_d = alu_result;
      cdb_tag_d  = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && capture) begin
      assert (alu_result_valid)
        else $error("alu_sched: alu_result_valid low when capturing result for tag %0d", tag_q);
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized bench for alu_sched with a transaction-level reference model and directed scenarios.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int TW = 6;
  localparam int L  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush;
  logic [N-1:0]  req_valid, req_ready;
  op_t           req_op  [N];
  logic [DW-1:0] req_lhs [N];
  logic [DW-1:0] req_rhs [N];
  logic [TW-1:0] req_tag [N];
  op_t           alu_op;
  logic [DW-1:0] alu_lhs, alu_rhs, alu_result, cdb_data;
  logic          alu_lhs_valid, alu_rhs_valid, alu_result_valid;
  logic          cdb_valid, cdb_ready, busy;
  logic [TW-1:0] cdb_tag;

  alu_sched #(
    .DATA_WIDTH(DW), .NUM_REQ(N), .TAG_WIDTH(TW), .MULDIV_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_tag(req_tag),
    .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
    .alu_lhs_valid(alu_lhs_valid), .alu_rhs_valid(alu_rhs_valid),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic op_t mk_op(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    op_t o;
    o.funct7 = f7;
    o.funct3 = f3;
    o.opcode = opc;
    return o;
  endfunction

  function automatic bit tb_muldiv(input op_t o);
    return ((o.opcode == 7'h33) || (o.opcode == 7'h3B)) && (o.funct7 == 7'h01);
  endfunction

  function automatic logic [DW-1:0] ref_alu(input op_t o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (tb_muldiv(o)) begin
      if (o.funct3 == 3'd4) return (b == '0) ? '1 : a / b;
      return a * b;
    end
    if (o.funct7 == 7'h20) return a - b;
    case (o.funct3)
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return a + b;
    endcase
  endfunction

  // Stand-in for the execute-stage ALU wired beside the scheduler.
  always_comb begin
    alu_result       = ref_alu(alu_op, alu_lhs, alu_rhs);
    alu_result_valid = alu_lhs_valid & alu_rhs_valid;
  end

  // Reference model: one job in flight, one pending result, a rotating priority pointer.
  bit            m_job, m_pend;
  op_t           m_op;
  logic [DW-1:0] m_lhs, m_rhs, m_data;
  logic [TW-1:0] m_tag, m_ptag;
  int            m_left, m_ptr;

  task automatic m_reset();
    m_job = 0; m_pend = 0; m_op = '0; m_lhs = '0; m_rhs = '0; m_data = '0;
    m_tag = '0; m_ptag = '0; m_left = 0; m_ptr = 0;
  endtask

  function automatic int model_pick();
    if (!rst_n || flush || m_job || (m_pend && !cdb_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int gi);
    if (flush) begin
      m_job  = 0;
      m_pend = 0;
      return;
    end
    if (m_pend && cdb_ready) m_pend = 0;
    if (m_job) begin
      if (m_left == 1) begin
        m_pend = 1;
        m_data = ref_alu(m_op, m_lhs, m_rhs);
        m_ptag = m_tag;
        m_job  = 0;
      end else begin
        m_left--;
      end
    end
    if (gi >= 0) begin
      m_job  = 1;
      m_op   = req_op[gi];
      m_lhs  = req_lhs[gi];
      m_rhs  = req_rhs[gi];
      m_tag  = req_tag[gi];
      m_left = tb_muldiv(req_op[gi]) ? L : 1;
      m_ptr  = (gi + 1) % N;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: compare against the model mid-cycle, advance the model at the edge.
  task automatic tick();
    int gi;
    logic [N-1:0] eg;
    @(negedge clk);
    gi = model_pick();
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("alu_op", 64'(alu_op), m_job ? 64'(m_op) : 64'd0);
    chk("alu_lhs", alu_lhs, m_job ? m_lhs : 64'd0);
    chk("alu_rhs", alu_rhs, m_job ? m_rhs : 64'd0);
    chk("alu_lhs_valid", 64'(alu_lhs_valid), 64'(m_job));
    chk("alu_rhs_valid", 64'(alu_rhs_valid), 64'(m_job));
    chk("cdb_valid", 64'(cdb_valid), 64'(m_pend));
    chk("busy", 64'(busy), 64'(m_job | m_pend));
    if (m_pend) begin
      chk("cdb_data", cdb_data, m_data);
      chk("cdb_tag", 64'(cdb_tag), 64'(m_ptag));
    end
    if (!rst_n) begin
      chk("cdb_data_rst", cdb_data, 64'd0);
      chk("cdb_tag_rst", 64'(cdb_tag), 64'd0);
    end
    @(posedge clk);
    if (!rst_n) m_reset();
    else model_update(gi);
    #1;
  endtask

  task automatic set_req(input int i, input op_t o, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] t);
    req_valid[i] = 1'b1;
    req_op[i]    = o;
    req_lhs[i]   = a;
    req_rhs[i]   = b;
    req_tag[i]   = t;
  endtask

  function automatic op_t rand_op();
    logic [6:0] opcs [3];
    logic [6:0] f7s  [3];
    logic [2:0] f3s  [4];
    opcs = '{7'h33, 7'h3B, 7'h13};
    f7s  = '{7'h00, 7'h01, 7'h20};
    f3s  = '{3'd0, 3'd4, 3'd6, 3'd7};
    return mk_op(f7s[$urandom_range(0, 2)], f3s[$urandom_range(0, 3)], opcs[$urandom_range(0, 2)]);
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  op_t op_add, op_mul, op_div;
  int  order [$];
  int  want  [5] = '{0, 1, 2, 3, 0};

  initial begin
    op_add = mk_op(7'h00, 3'd0, 7'h33);
    op_mul = mk_op(7'h01, 3'd0, 7'h33);
    op_div = mk_op(7'h01, 3'd4, 7'h33);
    m_reset();
    rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, op_add, '0, '0, '0);
    req_valid = '1;
    #1;

    // Reset state, with every requester asking.
    tick(); tick();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_data", cdb_data, 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    rst_n = 1'b1;
    req_valid = '0;
    tick();

    // Round robin with all four requesters held valid.
    for (int i = 0; i < N; i++) set_req(i, op_add, 64'(i), 64'd1, TW'(10 + i));
    cdb_ready = 1'b1;
    for (int c = 0; c < 20 && order.size() < 5; c++) begin
      #1;
      if (req_ready != '0) order.push_back(onehot_idx(req_ready));
      tick();
    end
    chk("rr_grant_count", 64'(order.size()), 64'd5);
    for (int i = 0; i < 5; i++) if (i < order.size()) chk("rr_order", 64'(order[i]), 64'(want[i]));
    req_valid = '0;
    repeat (4) tick();

    // Single ADD from requester 2.
    set_req(2, op_add, 64'd5, 64'd7, 6'd9);
    #1; chk("add_req_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    #1; chk("add_busy_exec", 64'(busy), 64'd1);
    tick();
    #1;
    chk("add_cdb_valid", 64'(cdb_valid), 64'd1);
    chk("add_cdb_data", cdb_data, 64'd12);
    chk("add_cdb_tag", 64'(cdb_tag), 64'd9);
    tick();
    #1; chk("add_busy_done", 64'(busy), 64'd0);
    tick();

    // MUL 3 * -4 with default latency; others knock during EXEC.
    set_req(0, op_mul, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 6'd5);
    tick();
    for (int c = 1; c <= 4; c++) begin
      for (int i = 0; i < N; i++) set_req(i, op_add, 64'd1, 64'd1, 6'd1);
      #1;
      chk("mul_req_ready_exec", 64'(req_ready), 64'd0);
      chk("mul_no_early_cdb", 64'(cdb_valid), 64'd0);
      tick();
    end
    req_valid = '0;
    #1;
    chk("mul_cdb_valid", 64'(cdb_valid), 64'd1);
    chk("mul_cdb_data", cdb_data, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("mul_cdb_tag", 64'(cdb_tag), 64'd5);
    chk("mul_req_ready_c5", 64'(req_ready), 64'd0);
    tick(); tick();

    // CDB stall, then release together with a pending requester 1.
    cdb_ready = 1'b0;
    set_req(3, op_add, 64'd100, 64'd23, 6'd33);
    #1; chk("stall_grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    tick();
    set_req(1, op_add, 64'd1, 64'd2, 6'd7);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_cdb_valid", 64'(cdb_valid), 64'd1);
      chk("stall_cdb_data", cdb_data, 64'd123);
      chk("stall_cdb_tag", 64'(cdb_tag), 64'd33);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    cdb_ready = 1'b1;
    #1; chk("release_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("release_cdb_data", cdb_data, 64'd3);
    chk("release_cdb_tag", 64'(cdb_tag), 64'd7);
    tick(); tick();

    // Flush in the second EXEC cycle of a DIV.
    set_req(0, op_div, 64'd50, 64'd5, 6'd20);
    tick();
    req_valid = '0;
    tick();
    flush = 1'b1;
    set_req(2, op_add, 64'd8, 64'd9, 6'd21);
    #1; chk("flush_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_new_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("flush_next_tag", 64'(cdb_tag), 64'd21);
    chk("flush_next_data", cdb_data, 64'd17);
    tick(); tick();

    // Asynchronous reset in the middle of EXEC.
    set_req(2, op_mul, 64'd6, 64'd7, 6'd40);
    tick(); tick();
    rst_n = 1'b0;
    m_reset();
    req_valid = '1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_alu_valid", 64'(alu_lhs_valid), 64'd0);
    chk("arst_alu_lhs", alu_lhs, 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_cdb_valid", 64'(cdb_valid), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1; chk("arst_first_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 40);
        req_op[i]    = rand_op();
        req_lhs[i]   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
        req_rhs[i]   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
        req_tag[i]   = TW'($urandom);
      end
      cdb_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 3);
      if ((c % 700) == 350) begin
        rst_n = 1'b0;
        m_reset();
        tick(); tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
